// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: ALU function codes, forward selects, ID/EX bundle.
// Imported by the execute-stage operand logic and its forwarding muxes.
package mips_pkg;

  localparam int XLEN  = 32;
  localparam int RBITS = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [XLEN-1:0]  imm;
    logic [RBITS-1:0] rs;
    logic [RBITS-1:0] rt;
    logic [RBITS-1:0] rd;
    logic [4:0]       shamt;
    logic [3:0]       alucontrol;
    logic             alusrc;
    logic             regdst;
    logic             regwrite;
    logic             memtoreg;
    logic             memwrite;
  } id_ex_t;

endpackage

// File: rtl/fwd_select.sv
// Forwarding mux for one source operand: MEM result, then WB result, else regfile.
// Ports: i_src, MEM/WB dest+enable, three data words in; o_sel, o_data out.
module fwd_select
  import mips_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic [REGBITS-1:0] i_src,
  input  logic [REGBITS-1:0] i_writereg_m,
  input  logic               i_regwrite_m,
  input  logic [REGBITS-1:0] i_writereg_w,
  input  logic               i_regwrite_w,
  input  logic [WIDTH-1:0]   i_reg_data,
  input  logic [WIDTH-1:0]   i_mem_data,
  input  logic [WIDTH-1:0]   i_wb_data,
  output fwd_sel_t           o_sel,
  output logic [WIDTH-1:0]   o_data
);

  logic w_hit_m;
  logic w_hit_w;

  // $zero is hardwired, so a write to it never produces a value to forward.
  assign w_hit_m = i_regwrite_m && (i_writereg_m != '0) &&
                   (i_writereg_m == i_src);
  assign w_hit_w = i_regwrite_w && (i_writereg_w != '0) &&
                   (i_writereg_w == i_src);

  always_comb begin
    o_sel = FWD_REG;
    if (w_hit_m)
      o_sel = FWD_MEM;
    else if (w_hit_w)
      o_sel = FWD_WB;
  end

  always_comb begin
    o_data = i_reg_data;
    unique case (o_sel)
      FWD_MEM: o_data = i_mem_data;
      FWD_WB:  o_data = i_wb_data;
      default: o_data = i_reg_data;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register plus execute-stage operand selection with MEM/WB forwarding.
// Inputs: decode fields (_d), stall/flush, MEM/WB results; outputs: ALU operands/ctl (_e).
module ex_operand_stage
  import mips_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_e,
  input  logic               flush_e,
  input  logic [WIDTH-1:0]   rd1_d,
  input  logic [WIDTH-1:0]   rd2_d,
  input  logic [WIDTH-1:0]   imm_d,
  input  logic [REGBITS-1:0] rs_d,
  input  logic [REGBITS-1:0] rt_d,
  input  logic [REGBITS-1:0] rd_d,
  input  logic [4:0]         shamt_d,
  input  logic [3:0]         alucontrol_d,
  input  logic               alusrc_d,
  input  logic               regdst_d,
  input  logic               regwrite_d,
  input  logic               memtoreg_d,
  input  logic               memwrite_d,
  input  logic [REGBITS-1:0] writereg_m,
  input  logic               regwrite_m,
  input  logic [WIDTH-1:0]   aluout_m,
  input  logic [REGBITS-1:0] writereg_w,
  input  logic               regwrite_w,
  input  logic [WIDTH-1:0]   result_w,
  output logic [WIDTH-1:0]   src_a_e,
  output logic [WIDTH-1:0]   src_b_e,
  output logic [3:0]         alucontrol_e,
  output logic [4:0]         shamt_e,
  output logic [WIDTH-1:0]   writedata_e,
  output logic [REGBITS-1:0] writereg_e,
  output logic [REGBITS-1:0] rs_e,
  output logic [REGBITS-1:0] rt_e,
  output logic               regwrite_e,
  output logic               memtoreg_e,
  output logic               memwrite_e
);

  id_ex_t   w_d;
  id_ex_t   r_e;
  fwd_sel_t w_sel_a;
  fwd_sel_t w_sel_b;

  always_comb begin
    w_d            = '0;
    w_d.rd1        = rd1_d;
    w_d.rd2        = rd2_d;
    w_d.imm        = imm_d;
    w_d.rs         = rs_d;
    w_d.rt         = rt_d;
    w_d.rd         = rd_d;
    w_d.shamt      = shamt_d;
    w_d.alucontrol = alucontrol_d;
    w_d.alusrc     = alusrc_d;
    w_d.regdst     = regdst_d;
    w_d.regwrite   = regwrite_d;
    w_d.memtoreg   = memtoreg_d;
    w_d.memwrite   = memwrite_d;
  end

  // A bubble is all zeros: no write, no store, and rs/rt = $zero never forward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_e <= '0;
    else if (flush_e)
      r_e <= '0;
    else if (!stall_e)
      r_e <= w_d;
  end

  fwd_select #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_fwd_a (
    .i_src        (r_e.rs),
    .i_writereg_m (writereg_m),
    .i_regwrite_m (regwrite_m),
    .i_writereg_w (writereg_w),
    .i_regwrite_w (regwrite_w),
    .i_reg_data   (r_e.rd1),
    .i_mem_data   (aluout_m),
    .i_wb_data    (result_w),
    .o_sel        (w_sel_a),
    .o_data       (src_a_e)
  );

  fwd_select #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_fwd_b (
    .i_src        (r_e.rt),
    .i_writereg_m (writereg_m),
    .i_regwrite_m (regwrite_m),
    .i_writereg_w (writereg_w),
    .i_regwrite_w (regwrite_w),
    .i_reg_data   (r_e.rd2),
    .i_mem_data   (aluout_m),
    .i_wb_data    (result_w),
    .o_sel        (w_sel_b),
    .o_data       (writedata_e)
  );

  assign src_b_e      = r_e.alusrc ? r_e.imm : writedata_e;
  assign writereg_e   = r_e.regdst ? r_e.rd : r_e.rt;
  assign alucontrol_e = r_e.alucontrol;
  assign shamt_e      = r_e.shamt;
  assign rs_e         = r_e.rs;
  assign rt_e         = r_e.rt;
  assign regwrite_e   = r_e.regwrite;
  assign memtoreg_e   = r_e.memtoreg;
  assign memwrite_e   = r_e.memwrite;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: vector table, hand sequences, random vs model.
// Model tracks the E register per load/stall/flush/reset rules.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall_e, flush_e;
  logic [31:0] rd1_d, rd2_d, imm_d;
  logic [4:0]  rs_d, rt_d, rd_d, shamt_d;
  logic [3:0]  alucontrol_d;
  logic        alusrc_d, regdst_d, regwrite_d, memtoreg_d, memwrite_d;
  logic [4:0]  writereg_m, writereg_w;
  logic        regwrite_m, regwrite_w;
  logic [31:0] aluout_m, result_w;
  logic [31:0] src_a_e, src_b_e, writedata_e;
  logic [3:0]  alucontrol_e;
  logic [4:0]  shamt_e, writereg_e, rs_e, rt_e;
  logic        regwrite_e, memtoreg_e, memwrite_e;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .shamt_d(shamt_d),
    .alucontrol_d(alucontrol_d), .alusrc_d(alusrc_d),
    .regdst_d(regdst_d), .regwrite_d(regwrite_d),
    .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d),
    .writereg_m(writereg_m), .regwrite_m(regwrite_m),
    .aluout_m(aluout_m), .writereg_w(writereg_w),
    .regwrite_w(regwrite_w), .result_w(result_w),
    .src_a_e(src_a_e), .src_b_e(src_b_e),
    .alucontrol_e(alucontrol_e), .shamt_e(shamt_e),
    .writedata_e(writedata_e), .writereg_e(writereg_e),
    .rs_e(rs_e), .rt_e(rt_e), .regwrite_e(regwrite_e),
    .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd, shamt;
    logic [3:0]  alu;
    logic        alusrc, regdst, regwrite, memtoreg, memwrite;
  } ex_t;

  ex_t m;
  ex_t zero_e;

  function automatic ex_t cur_d();
    ex_t e;
    e.rd1 = rd1_d; e.rd2 = rd2_d; e.imm = imm_d;
    e.rs = rs_d; e.rt = rt_d; e.rd = rd_d; e.shamt = shamt_d;
    e.alu = alucontrol_d; e.alusrc = alusrc_d; e.regdst = regdst_d;
    e.regwrite = regwrite_d; e.memtoreg = memtoreg_d;
    e.memwrite = memwrite_d;
    return e;
  endfunction

  // Value register 'src' really holds as seen by the instruction in E.
  function automatic logic [31:0] fwd(input logic [4:0] src,
                                      input logic [31:0] regv);
    if (src == 0) return regv;
    if (regwrite_m && writereg_m == src) return aluout_m;
    if (regwrite_w && writereg_w == src) return result_w;
    return regv;
  endfunction

  task automatic check_model(input string tag);
    logic [31:0] a, wd, b;
    a  = fwd(m.rs, m.rd1);
    wd = fwd(m.rt, m.rd2);
    b  = m.alusrc ? m.imm : wd;
    chk({tag, ".src_a"}, src_a_e, a);
    chk({tag, ".src_b"}, src_b_e, b);
    chk({tag, ".wdata"}, writedata_e, wd);
    chk({tag, ".wreg"}, {27'd0, writereg_e},
        {27'd0, m.regdst ? m.rd : m.rt});
    chk({tag, ".ctl"},
        {17'd0, alucontrol_e, shamt_e, rs_e, rt_e,
         regwrite_e, memtoreg_e, memwrite_e},
        {17'd0, m.alu, m.shamt, m.rs, m.rt,
         m.regwrite, m.memtoreg, m.memwrite});
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset)        m = zero_e;
    else if (flush_e) m = zero_e;
    else if (!stall_e) m = cur_d();
    #1;
  endtask

  task automatic rand_d();
    rd1_d = $urandom; rd2_d = $urandom; imm_d = $urandom;
    rs_d = 5'($urandom_range(0, 7)); rt_d = 5'($urandom_range(0, 7));
    rd_d = 5'($urandom_range(0, 31)); shamt_d = 5'($urandom);
    alucontrol_d = 4'($urandom);
    {alusrc_d, regdst_d, regwrite_d, memtoreg_d, memwrite_d} = 5'($urandom);
  endtask

  task automatic rand_fwd();
    writereg_m = 5'($urandom_range(0, 7));
    writereg_w = 5'($urandom_range(0, 7));
    regwrite_m = 1'($urandom); regwrite_w = 1'($urandom);
    aluout_m = $urandom; result_w = $urandom;
  endtask

  task automatic no_fwd();
    writereg_m = 0; regwrite_m = 0; aluout_m = 0;
    writereg_w = 0; regwrite_w = 0; result_w = 0;
  endtask

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2, imm;
    logic        alusrc, regdst;
    logic [3:0]  alu;
    logic [4:0]  shamt;
    logic [2:0]  ctl;
    logic [4:0]  wm;
    logic        rwm;
    logic [31:0] aluout;
    logic [4:0]  ww;
    logic        rww;
    logic [31:0] res;
    logic [31:0] ea, eb, ewd;
    logic [4:0]  ewr;
  } vec_t;

  vec_t v[8];

  initial begin
    logic [31:0] held_a;
    logic [4:0]  held_rs;

    zero_e = '{default: 0};
    m = zero_e;

    v[0] = '{5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h0, 1'b0, 1'b0,
             4'b0010, 5'd0, 3'b100, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0,
             32'h5, 32'h7, 32'h7, 5'd2};
    v[1] = '{5'd3, 5'd5, 5'd0, 32'h111, 32'h222, 32'h0, 1'b0, 1'b0,
             4'b1010, 5'd1, 3'b110, 5'd3, 1'b1, 32'h10, 5'd3, 1'b1, 32'h20,
             32'h10, 32'h222, 32'h222, 5'd5};
    v[2] = '{5'd6, 5'd4, 5'd0, 32'h66, 32'h44, 32'h0, 1'b0, 1'b0,
             4'b0001, 5'd2, 3'b001, 5'd9, 1'b1, 32'hAA, 5'd4, 1'b1, 32'h55,
             32'h66, 32'h55, 32'h55, 5'd4};
    v[3] = '{5'd0, 5'd0, 5'd0, 32'h123, 32'h456, 32'h0, 1'b0, 1'b0,
             4'b0111, 5'd31, 3'b111, 5'd0, 1'b1, 32'hDEAD, 5'd0, 1'b1,
             32'hBEEF, 32'h123, 32'h456, 32'h456, 5'd0};
    v[4] = '{5'd1, 5'd7, 5'd0, 32'h1, 32'h2, 32'hFFFFFFFC, 1'b1, 1'b0,
             4'b0011, 5'd0, 3'b001, 5'd8, 1'b1, 32'h77, 5'd7, 1'b1, 32'h99,
             32'h1, 32'hFFFFFFFC, 32'h99, 5'd7};
    v[5] = '{5'd1, 5'd2, 5'd9, 32'h31, 32'h32, 32'h0, 1'b0, 1'b1,
             4'b0100, 5'd7, 3'b100, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0,
             32'h31, 32'h32, 32'h32, 5'd9};
    v[6] = '{5'd3, 5'd1, 5'd0, 32'h5, 32'h6, 32'h0, 1'b0, 1'b0,
             4'b0101, 5'd3, 3'b100, 5'd3, 1'b0, 32'h10, 5'd3, 1'b1, 32'h20,
             32'h20, 32'h6, 32'h6, 5'd1};
    v[7] = '{5'd10, 5'd11, 5'd0, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0,
             4'b1011, 5'd0, 3'b100, 5'd10, 1'b1, 32'hA0, 5'd11, 1'b1, 32'hB0,
             32'hA0, 32'hB0, 32'hB0, 5'd11};

    reset = 1'b1; stall_e = 0; flush_e = 0;
    rand_d(); no_fwd();
    #12;
    check_model("por");
    @(negedge clk); reset = 1'b0;

    // Load nonzero state, then reset mid-cycle: outputs clear at once.
    rand_d(); rs_d = 5'd3; regwrite_d = 1; memwrite_d = 1;
    tick();
    @(negedge clk);
    writereg_m = 5'd5; regwrite_m = 1; aluout_m = 32'h1234;
    reset = 1'b1; #1;
    m = zero_e;
    chk("async_rst.src_a", src_a_e, 32'h0);
    chk("async_rst.wreg", {27'd0, writereg_e}, 32'h0);
    chk("async_rst.regwrite", {31'd0, regwrite_e}, 32'h0);
    check_model("async_rst");
    @(negedge clk); reset = 1'b0; no_fwd();
    rand_d(); rd1_d = 5; rd2_d = 7; alusrc_d = 0; rs_d = 1; rt_d = 2;
    tick();
    chk("first_load.src_a", src_a_e, 32'd5);
    chk("first_load.src_b", src_b_e, 32'd7);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      no_fwd();
      rs_d = v[i].rs; rt_d = v[i].rt; rd_d = v[i].rd;
      rd1_d = v[i].rd1; rd2_d = v[i].rd2; imm_d = v[i].imm;
      alusrc_d = v[i].alusrc; regdst_d = v[i].regdst;
      alucontrol_d = v[i].alu; shamt_d = v[i].shamt;
      {regwrite_d, memtoreg_d, memwrite_d} = v[i].ctl;
      tick();
      writereg_m = v[i].wm; regwrite_m = v[i].rwm; aluout_m = v[i].aluout;
      writereg_w = v[i].ww; regwrite_w = v[i].rww; result_w = v[i].res;
      #1;
      chk($sformatf("vec%0d.src_a", i), src_a_e, v[i].ea);
      chk($sformatf("vec%0d.src_b", i), src_b_e, v[i].eb);
      chk($sformatf("vec%0d.wdata", i), writedata_e, v[i].ewd);
      chk($sformatf("vec%0d.wreg", i), {27'd0, writereg_e},
          {27'd0, v[i].ewr});
      chk($sformatf("vec%0d.ctl", i),
          {20'd0, alucontrol_e, shamt_e, regwrite_e, memtoreg_e, memwrite_e},
          {20'd0, v[i].alu, v[i].shamt, v[i].ctl});
    end

    // Stall two cycles while decode changes; E must hold.
    @(negedge clk); no_fwd();
    rand_d(); rs_d = 5'd6; rd1_d = 32'hCAFE0001;
    tick();
    held_a = 32'hCAFE0001; held_rs = 5'd6;
    stall_e = 1;
    for (int k = 0; k < 2; k++) begin
      rand_d();
      tick();
      chk($sformatf("stall%0d.rs", k), {27'd0, rs_e}, {27'd0, held_rs});
      chk($sformatf("stall%0d.src_a", k), src_a_e, held_a);
      // Forwarding stays live while E is held.
      writereg_m = held_rs; regwrite_m = 1; aluout_m = 32'h600D + k; #1;
      chk($sformatf("stall%0d.fwd", k), src_a_e, 32'h600D + k);
      no_fwd();
    end

    // Flush beats stall.
    regwrite_d = 1; memwrite_d = 1; regdst_d = 1; rd_d = 9;
    flush_e = 1;
    tick();
    chk("flush.regwrite", {31'd0, regwrite_e}, 32'h0);
    chk("flush.memwrite", {31'd0, memwrite_e}, 32'h0);
    chk("flush.wreg", {27'd0, writereg_e}, 32'h0);
    flush_e = 0;

    // Reset during a stall: state clears and the stall keeps it zero.
    stall_e = 0; rand_d(); alucontrol_d = 4'b1011; rd_d = 5'd17;
    regdst_d = 1; tick();
    stall_e = 1;
    @(negedge clk); reset = 1; #1; m = zero_e;
    @(negedge clk); reset = 0; rand_d();
    tick();
    chk("rst_stall.alu", {28'd0, alucontrol_e}, 32'h0);
    chk("rst_stall.wreg", {27'd0, writereg_e}, 32'h0);
    stall_e = 0;

    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      rand_d();
      stall_e = ($urandom_range(0, 3) == 0);
      flush_e = ($urandom_range(0, 9) == 0);
      rand_fwd();
      tick();
      rand_fwd(); #1;
      check_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
